// File: rtl/mux_7to1_pkg.sv
// -----------------------------------------------------------------------------
// mux_7to1_pkg
// Shared constants and types for the registered 7:1 selector.
//   NUM_INPUTS  : number of data inputs (codes 0..6)
//   SEL_W       : select code width
//   SEL_INVALID : the one code with no data input behind it
//   WIDTH_MIN/MAX : legal range of the data width parameter
// -----------------------------------------------------------------------------
package mux_7to1_pkg;

  localparam int NUM_INPUTS = 7;
  localparam int SEL_W      = 3;
  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 64;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_INVALID = 3'd7;

endpackage : mux_7to1_pkg

// File: rtl/mux_7to1_core.sv
// -----------------------------------------------------------------------------
// mux_7to1_core
// Purely combinational part of the selector: one-hot decode of the select code,
// AND-OR data selection and detection of the unused code.
// Ports:
//   in0..in6 : input  [WIDTH-1:0]  data inputs, chosen by codes 0..6
//   sel      : input  sel_t        select code
//   data     : output [WIDTH-1:0]  selected value (all zeros for the invalid code)
//   invalid  : output              high when sel is the invalid code
// -----------------------------------------------------------------------------
module mux_7to1_core
  import mux_7to1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  sel_t             sel,
  output logic [WIDTH-1:0] data,
  output logic             invalid
);

  logic [WIDTH-1:0] in_arr [NUM_INPUTS];
  logic [WIDTH-1:0] masked [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] onehot;

  assign in_arr[0] = in0;
  assign in_arr[1] = in1;
  assign in_arr[2] = in2;
  assign in_arr[3] = in3;
  assign in_arr[4] = in4;
  assign in_arr[5] = in5;
  assign in_arr[6] = in6;

  // Each input is gated by its own decode term. The invalid code matches no
  // term, so the OR below collapses to zero without a separate override.
  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_lane
      assign onehot[gi] = (sel == sel_t'(gi));
      assign masked[gi] = in_arr[gi] & {WIDTH{onehot[gi]}};
    end
  endgenerate

  always_comb begin
    data = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      data = data | masked[i];
    end
  end

  assign invalid = (sel == SEL_INVALID);

endmodule : mux_7to1_core

// File: rtl/mux_7to1.sv
// -----------------------------------------------------------------------------
// mux_7to1
// Registered seven-input selector. The selected value and the invalid-code
// flag are captured every rising edge (no enable), giving a glitch-free output
// exactly one cycle after the select/data are sampled.
// Ports:
//   clk      : input               system clock, rising edge
//   rst_n    : input               synchronous active-low reset
//   in0..in6 : input  [WIDTH-1:0]  data inputs
//   sel      : input  [2:0]        select code (7 = invalid)
//   z        : output [WIDTH-1:0]  registered selected data (0 after code 7)
//   sel_err  : output              registered flag, high when previous sel was 7
// -----------------------------------------------------------------------------
module mux_7to1
  import mux_7to1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] z,
  output logic             sel_err
);

  // Elaboration-time guard on the data width.
  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
      $error("mux_7to1: WIDTH=%0d outside legal range %0d..%0d",
             WIDTH, WIDTH_MIN, WIDTH_MAX);
    end
  endgenerate

  logic [WIDTH-1:0] z_next;
  logic             sel_err_next;
  logic [WIDTH-1:0] z_reg;
  logic             sel_err_reg;

  mux_7to1_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .in0     (in0),
    .in1     (in1),
    .in2     (in2),
    .in3     (in3),
    .in4     (in4),
    .in5     (in5),
    .in6     (in6),
    .sel     (sel_t'(sel)),
    .data    (z_next),
    .invalid (sel_err_next)
  );

  // Reset wins over any select value on the edge that samples it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z_reg       <= '0;
      sel_err_reg <= 1'b0;
    end else begin
      z_reg       <= z_next;
      sel_err_reg <= sel_err_next;
    end
  end

  assign z       = z_reg;
  assign sel_err = sel_err_reg;

endmodule : mux_7to1

// File: tb/tb_mux_7to1.sv
// Self-checking bench: two instances (WIDTH=1 and WIDTH=8) share clock, reset
// and select; each has its own data inputs. Expected values come from a
// behavioural model: out = reset ? 0 : (sel == 7 ? 0 : data[sel]).
module tb_mux_7to1;

  logic       clk;
  logic       rst_n;
  logic [2:0] sel;
  logic       d1 [7];
  logic [7:0] d8 [7];
  logic       z1, err1;
  logic [7:0] z8;
  logic       err8;

  logic       exp1;
  logic [7:0] exp8;
  logic       exp_err;

  int checks = 0;
  int errors = 0;

  mux_7to1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in0(d1[0]), .in1(d1[1]), .in2(d1[2]), .in3(d1[3]),
    .in4(d1[4]), .in5(d1[5]), .in6(d1[6]),
    .sel(sel), .z(z1), .sel_err(err1)
  );

  mux_7to1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in0(d8[0]), .in1(d8[1]), .in2(d8[2]), .in3(d8[3]),
    .in4(d8[4]), .in5(d8[5]), .in6(d8[6]),
    .sel(sel), .z(z8), .sel_err(err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, evaluated on the values about to be sampled.
  task automatic predict();
    if (!rst_n) begin
      exp1 = 1'b0; exp8 = 8'h00; exp_err = 1'b0;
    end else if (sel == 3'd7) begin
      exp1 = 1'b0; exp8 = 8'h00; exp_err = 1'b1;
    end else begin
      exp1 = d1[int'(sel)]; exp8 = d8[int'(sel)]; exp_err = 1'b0;
    end
  endtask

  // Advance one edge, then sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
    $display("[%0t] txn rst_n=%0b sel=%0d z1=%b z8=%h sel_err=%b/%b",
             $time, rst_n, sel, z1, z8, err1, err8);
  endtask

  task automatic randomize_data();
    for (int i = 0; i < 7; i++) begin
      d1[i] = 1'($urandom);
      d8[i] = 8'($urandom);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sel   = 3'd3;
    for (int i = 0; i < 7; i++) begin
      d1[i] = 1'b1;
      d8[i] = 8'hFF;
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (z1 !== 1'b0 || z8 !== 8'h00 || err1 !== 1'b0 || err8 !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc%0d got z1=%b z8=%h err=%b/%b exp 0 00 0/0",
                 c, z1, z8, err1, err8);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (z1 !== 1'b1 || z8 !== 8'hFF || err1 !== 1'b0 || err8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got z1=%b z8=%h err=%b/%b exp 1 ff 0/0",
               z1, z8, err1, err8);
    end
  endtask

  // Step sel 0..6; optionally pull reset for the edge at code 5.
  task automatic test_sweep(input bit mid_reset);
    logic pat [7];
    pat = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) d1[i] = pat[i];
    for (int k = 0; k < 7; k++) begin
      sel = 3'(k);
      for (int i = 0; i < 7; i++) d8[i] = 8'($urandom);
      rst_n = (mid_reset && k == 5) ? 1'b0 : 1'b1;
      predict();
      tick();
      checks++;
      if (z1 !== exp1 || z8 !== exp8 || err1 !== exp_err || err8 !== exp_err) begin
        errors++;
        $display("FAIL sweep%s sel=%0d got z1=%b z8=%h err=%b/%b exp %b %h %b",
                 mid_reset ? "_midreset" : "", k, z1, z8, err1, err8,
                 exp1, exp8, exp_err);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_invalid();
    for (int i = 0; i < 7; i++) begin
      d1[i] = 1'b1;
      d8[i] = 8'hFF;
    end
    sel = 3'd7;
    tick();
    checks++;
    if (z1 !== 1'b0 || z8 !== 8'h00 || err1 !== 1'b1 || err8 !== 1'b1) begin
      errors++;
      $display("FAIL invalid got z1=%b z8=%h err=%b/%b exp 0 00 1/1",
               z1, z8, err1, err8);
    end
    d8[2] = 8'h3C;
    sel   = 3'd2;
    tick();
    checks++;
    if (z1 !== 1'b1 || z8 !== 8'h3C || err1 !== 1'b0 || err8 !== 1'b0) begin
      errors++;
      $display("FAIL invalid_recover got z1=%b z8=%h err=%b/%b exp 1 3c 0/0",
               z1, z8, err1, err8);
    end
  endtask

  task automatic test_isolation();
    sel   = 3'd4;
    d8[4] = 8'hA5;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 7; i++) begin
        if (i != 4) d8[i] = (c == 0) ? 8'($urandom) : ~d8[i];
      end
      tick();
      checks++;
      if (z8 !== 8'hA5 || err8 !== 1'b0) begin
        errors++;
        $display("FAIL isolation cyc%0d got z8=%h err=%b exp a5 0", c, z8, err8);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq [4];
    logic [7:0] ez  [4];
    logic       ee  [4];
    seq = '{3'd6, 3'd0, 3'd7, 3'd3};
    ez  = '{8'd7, 8'd1, 8'd0, 8'd4};
    ee  = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) d8[i] = 8'(i + 1);
    for (int s = 0; s < 4; s++) begin
      sel = seq[s];
      tick();
      checks++;
      if (z8 !== ez[s] || err8 !== ee[s]) begin
        errors++;
        $display("FAIL back_to_back step%0d got z8=%h err=%b exp %h %b",
                 s, z8, err8, ez[s], ee[s]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      randomize_data();
      sel   = 3'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 19) != 0);
      predict();
      tick();
      checks++;
      if (z1 !== exp1 || z8 !== exp8 || err1 !== exp_err || err8 !== exp_err) begin
        errors++;
        $display("FAIL random cyc%0d got z1=%b z8=%h err=%b/%b exp %b %h %b",
                 c, z1, z8, err1, err8, exp1, exp8, exp_err);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    sel   = 3'd0;
    for (int i = 0; i < 7; i++) begin
      d1[i] = 1'b0;
      d8[i] = 8'h00;
    end
    test_reset();
    test_sweep(1'b0);
    test_invalid();
    test_isolation();
    test_sweep(1'b1);
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux_7to1
